// File: rtl/priority_code_uart_logger.sv
// Logs every change of the priority encoder's code as UART 8N1 frames through a small FIFO.
// Build option PRIO_LOG_TIMESTAMP_EN: each event is also stamped and sent as code frame + stamp frame.
module priority_code_uart_logger #(
  parameter int         DEPTH        = 4,
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] NONE_CODE    = 8'hF0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [7:0]               code_in,
  input  logic                     clr_ovf,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef PRIO_LOG_TIMESTAMP_EN
  localparam int EW = 16;
`else
  localparam int EW = 8;
`endif
  localparam bit MULTI = (EW > 8);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    prev_code;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          evt, push, pop, full, empty, drop;

  assign evt   = en && (code_in != prev_code);
  assign full  = (fifo_count_o == CW'(DEPTH));
  assign empty = (fifo_count_o == '0);
  // a pop at the same edge frees the slot, so a push into a full FIFO still lands
  assign push  = evt && (!full || pop);
  assign drop  = evt && !push;

`ifdef PRIO_LOG_TIMESTAMP_EN
  logic [7:0] stamp;
  always_ff @(posedge clk) begin
    if (!rst_n)  stamp <= '0;
    else if (en) stamp <= stamp + 8'd1;
  end
  assign wr_entry = {code_in, stamp};
`else
  assign wr_entry = code_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_code    <= NONE_CODE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (evt)  prev_code <= code_in;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count_o <= fifo_count_o + CW'(push) - CW'(pop);
      if (drop)         overflow_o <= 1'b1;
      else if (clr_ovf) overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Transmitter: ser holds the whole entry; the top byte is the frame on the wire.
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [EW-1:0] ser_q, ser_d;
  logic          more_q, more_d;
  logic          tx_d, tick;

  assign tick   = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      ser_q   <= '0;
      more_q  <= 1'b0;
      tx_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      more_q  <= more_d;
      tx_o    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    more_d  = more_q;
    tx_d    = tx_o;
    pop     = 1'b0;
    if (state_q != IDLE) timer_d = tick ? '0 : timer_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ser_d   = mem[rd_ptr];
          more_d  = MULTI;
          timer_d = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = ser_q[EW-8];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = ser_q[EW-8+int'(bit_q)+1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          // second frame of a stamped entry goes out with no idle gap, busy stays high
          if (more_q) begin
            ser_d   = ser_q << 8;
            more_d  = 1'b0;
            state_d = START;
            tx_d    = 1'b0;
          end else if (!empty) begin
            pop     = 1'b1;
            ser_d   = mem[rd_ptr];
            more_d  = MULTI;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
